// File: rtl/wb_regfile_pkg.sv
// Shared widths and register-index constants for the 8-bit CPU pipeline.
package wb_regfile_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;

  // Index of the register that reads as zero when hardwiring is enabled.
  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

endpackage : wb_regfile_pkg

// File: rtl/wb_bypass_mux.sv
// One ID-stage read port: returns the in-flight writeback value when it
// targets the same register, otherwise the stored register contents.
module wb_bypass_mux #(
  parameter int DATA_W = wb_regfile_pkg::DATA_W,
  parameter int ADDR_W = wb_regfile_pkg::ADDR_W
) (
  input  logic [ADDR_W-1:0] idx,
  input  logic [DATA_W-1:0] stored,
  input  logic              commit,
  input  logic [ADDR_W-1:0] wr_idx,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] operand
);

  // Same-cycle write-to-read forwarding
  always_comb begin
    operand = stored;
    if (commit && (wr_idx == idx)) operand = wb_data;
  end

endmodule : wb_bypass_mux

// File: rtl/wb_regfile.sv
// Writeback select, 2**ADDR_W-entry register file with two bypassed read
// ports, an unbypassed debug port and a saturating committed-write counter.
module wb_regfile #(
  parameter int DATA_W  = wb_regfile_pkg::DATA_W,
  parameter int ADDR_W  = wb_regfile_pkg::ADDR_W,
  parameter bit R0_ZERO = 1'b1,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              WBregwr,
  input  logic              WBregomem,
  input  logic [DATA_W-1:0] readDATA,
  input  logic [DATA_W-1:0] ALUout,
  input  logic [ADDR_W-1:0] writeREG,
  input  logic [ADDR_W-1:0] readREG1,
  input  logic [ADDR_W-1:0] readREG2,
  output logic [DATA_W-1:0] readDATA1,
  output logic [DATA_W-1:0] readDATA2,
  output logic [DATA_W-1:0] wbDATA,
  input  logic [ADDR_W-1:0] dbgREG,
  output logic [DATA_W-1:0] dbgDATA,
  output logic [CNT_W-1:0]  wrCount
);

  import wb_regfile_pkg::*;

  localparam int NREGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

  // Flat flop array so the whole file clears on reset.
  logic [DATA_W-1:0] regs [NREGS];

  logic              commit;
  logic [DATA_W-1:0] op1;
  logic [DATA_W-1:0] op2;

  // Writeback source select, independent of reset and write enable
  always_comb begin
    wbDATA = WBregomem ? readDATA : ALUout;
  end

  // A write lands unless reset is active or it targets a hardwired r0
  always_comb begin
    commit = WBregwr && !rst && !(R0_ZERO && (writeREG == ZERO_IDX));
  end

  // Register storage: cleared on reset, written on commit
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (commit) begin
      regs[writeREG] <= wbDATA;
    end
  end

  // Committed-write counter, holds at all-ones instead of wrapping
  always_ff @(posedge clk) begin
    if (rst) begin
      wrCount <= '0;
    end else if (commit && (wrCount != '1)) begin
      wrCount <= wrCount + CNT_W'(1);
    end
  end

  wb_bypass_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port1 (
    .idx     (readREG1),
    .stored  (regs[readREG1]),
    .commit  (commit),
    .wr_idx  (writeREG),
    .wb_data (wbDATA),
    .operand (op1)
  );

  wb_bypass_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port2 (
    .idx     (readREG2),
    .stored  (regs[readREG2]),
    .commit  (commit),
    .wr_idx  (writeREG),
    .wb_data (wbDATA),
    .operand (op2)
  );

  // Operands read zero during reset and for a hardwired r0
  always_comb begin
    readDATA1 = op1;
    readDATA2 = op2;
    if (rst || (R0_ZERO && (readREG1 == ZERO_IDX))) readDATA1 = '0;
    if (rst || (R0_ZERO && (readREG2 == ZERO_IDX))) readDATA2 = '0;
  end

  // Debug view of storage only; a same-cycle commit is not yet visible here
  always_comb begin
    dbgDATA = regs[dbgREG];
    if (R0_ZERO && (dbgREG == ZERO_IDX)) dbgDATA = '0;
  end

endmodule : wb_regfile

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: the driver pushes expected outputs from an
// array-based reference model; a monitor on the falling edge pops and compares.
module tb_wb_regfile;

  localparam int DW = 8;
  localparam int AW = 3;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          WBregwr = 1'b0;
  logic          WBregomem = 1'b0;
  logic [DW-1:0] readDATA = '0;
  logic [DW-1:0] ALUout = '0;
  logic [AW-1:0] writeREG = '0;
  logic [AW-1:0] readREG1 = '0;
  logic [AW-1:0] readREG2 = '0;
  logic [AW-1:0] dbgREG = '0;
  logic [DW-1:0] readDATA1;
  logic [DW-1:0] readDATA2;
  logic [DW-1:0] wbDATA;
  logic [DW-1:0] dbgDATA;
  logic [CW-1:0] wrCount;

  always #5 clk = ~clk;

  wb_regfile #(.DATA_W(DW), .ADDR_W(AW), .R0_ZERO(1'b1), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .WBregwr   (WBregwr),
    .WBregomem (WBregomem),
    .readDATA  (readDATA),
    .ALUout    (ALUout),
    .writeREG  (writeREG),
    .readREG1  (readREG1),
    .readREG2  (readREG2),
    .readDATA1 (readDATA1),
    .readDATA2 (readDATA2),
    .wbDATA    (wbDATA),
    .dbgREG    (dbgREG),
    .dbgDATA   (dbgDATA),
    .wrCount   (wrCount)
  );

  typedef struct {
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;
    logic [DW-1:0] wb;
    logic [DW-1:0] dbg;
    logic [CW-1:0] cnt;
    string         tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: register contents and number of writes that landed.
  int unsigned model_regs [8];
  int unsigned model_writes = 0;

  function automatic int unsigned model_read(input int unsigned idx);
    return (idx == 0) ? 0 : model_regs[idx];
  endfunction

  task automatic cycle(input logic r, input logic w, input logic om,
                       input logic [7:0] rd, input logic [7:0] alu,
                       input logic [2:0] wi, input logic [2:0] a,
                       input logic [2:0] b, input logic [2:0] d,
                       input string tag);
    exp_t e;
    int unsigned wbv;
    bit lands;
    @(posedge clk);
    #1;
    rst = r; WBregwr = w; WBregomem = om; readDATA = rd; ALUout = alu;
    writeREG = wi; readREG1 = a; readREG2 = b; dbgREG = d;
    wbv   = om ? rd : alu;
    lands = w && !r && (wi != 0);
    e.tag = tag;
    e.wb  = wbv[7:0];
    e.dbg = model_read(d);
    e.cnt = (model_writes > 15) ? 4'hF : model_writes[3:0];
    if (r) begin
      e.rd1 = 0;
      e.rd2 = 0;
    end else begin
      e.rd1 = (a == 0) ? 0 : ((lands && wi == a) ? wbv[7:0] : model_read(a));
      e.rd2 = (b == 0) ? 0 : ((lands && wi == b) ? wbv[7:0] : model_read(b));
    end
    exp_q.push_back(e);
    if (r) begin
      foreach (model_regs[i]) model_regs[i] = 0;
      model_writes = 0;
    end else if (lands) begin
      model_regs[wi] = wbv;
      model_writes++;
    end
  endtask

  task automatic cmp(input string tag, input string name,
                     input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s %s: got %h expected %h", tag, name, act, req);
    end
  endtask

  // Monitor: outputs are combinational, so every driven cycle presents one response
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp(e.tag, "readDATA1", 16'(readDATA1), 16'(e.rd1));
        cmp(e.tag, "readDATA2", 16'(readDATA2), 16'(e.rd2));
        cmp(e.tag, "wbDATA",    16'(wbDATA),    16'(e.wb));
        cmp(e.tag, "dbgDATA",   16'(dbgDATA),   16'(e.dbg));
        cmp(e.tag, "wrCount",   16'(wrCount),   16'(e.cnt));
      end
    end
  end

  initial begin
    int budget;
    foreach (model_regs[i]) model_regs[i] = 0;
    repeat (2) @(posedge clk);

    // reset state
    cycle(1, 0, 0, 8'h00, 8'h00, 3'd0, 3'd1, 3'd2, 3'd3, "reset");
    // write r3 = 5A through ALU path, then observe on debug port
    cycle(0, 1, 0, 8'h00, 8'h5A, 3'd3, 3'd3, 3'd1, 3'd3, "alu_wr");
    cycle(0, 0, 0, 8'h00, 8'h00, 3'd0, 3'd3, 3'd3, 3'd3, "alu_rd");
    // load-path write with double bypass while debug shows old r5
    cycle(0, 1, 1, 8'hC3, 8'h12, 3'd5, 3'd5, 3'd5, 3'd5, "bypass2");
    cycle(0, 0, 1, 8'h00, 8'h00, 3'd0, 3'd5, 3'd5, 3'd5, "bypass2_after");
    // writes to r0 are dropped and never bypassed
    cycle(0, 1, 0, 8'h00, 8'hFF, 3'd0, 3'd0, 3'd0, 3'd0, "r0_write");
    cycle(0, 0, 0, 8'h00, 8'h00, 3'd0, 3'd0, 3'd3, 3'd0, "r0_after");
    // fill r1..r7, then reset while writing r2
    for (int i = 1; i < 8; i++)
      cycle(0, 1, 0, 8'h00, 8'(8'h11 * i), 3'(i), 3'(i), 3'(i - 1), 3'(i), "fill");
    cycle(1, 1, 0, 8'h00, 8'hEE, 3'd2, 3'd2, 3'd2, 3'd2, "rst_wr");
    for (int i = 1; i < 8; i++)
      cycle(0, 0, 0, 8'h00, 8'h00, 3'd0, 3'(i), 3'(i), 3'(i), "post_rst");
    // saturation of the write counter
    for (int i = 0; i < 20; i++)
      cycle(0, 1, i[0], 8'($urandom), 8'($urandom), 3'($urandom_range(1, 7)),
            3'($urandom), 3'($urandom), 3'($urandom), "saturate");
    // disabled write must not bypass or land
    cycle(0, 1, 0, 8'h00, 8'h44, 3'd4, 3'd4, 3'd4, 3'd4, "r4_set");
    cycle(0, 0, 0, 8'h00, 8'h99, 3'd4, 3'd4, 3'd4, 3'd4, "no_wr");
    cycle(0, 0, 0, 8'h00, 8'h00, 3'd0, 3'd4, 3'd4, 3'd4, "no_wr_after");
    // randomized traffic, occasional reset
    for (int i = 0; i < 400; i++)
      cycle(($urandom_range(0, 29) == 0), ($urandom_range(0, 9) < 7), 1'($urandom),
            8'($urandom), 8'($urandom), 3'($urandom), 3'($urandom), 3'($urandom),
            3'($urandom), "random");

    budget = 10;
    while (exp_q.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d responses unchecked, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_wb_regfile
